// File: rtl/br_pkg.sv
// Shared definitions for the BR register-file write-back path.
package br_pkg;

    localparam int unsigned XLEN_DEFAULT  = 32;
    localparam int unsigned NREGS_DEFAULT = 32;
    localparam int unsigned REG_AW        = 5;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_t;

endpackage

// File: rtl/br_scoreboard.sv
// Per-register pending-write scoreboard and decode hazard (RAW/WAW) stall.
module br_scoreboard
    import br_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     iss_valid,
    input  logic                     iss_wr,
    input  logic [$clog2(NREGS)-1:0] iss_rs1,
    input  logic [$clog2(NREGS)-1:0] iss_rs2,
    input  logic [$clog2(NREGS)-1:0] iss_rd,
    input  logic                     clr_en,
    input  logic [$clog2(NREGS)-1:0] clr_idx,
    output logic                     stall
);

    logic [NREGS-1:0] pend;
    logic [NREGS-1:0] pend_nxt;
    logic             set_en;

    assign stall  = iss_valid & (pend[iss_rs1] | pend[iss_rs2] | (iss_wr & pend[iss_rd]));
    assign set_en = iss_valid & iss_wr & ~stall & (iss_rd != '0);

    // Set is applied after clear so a fresh issue wins over a same-edge write-back.
    always_comb begin
        pend_nxt = pend;
        if (clr_en) begin
            pend_nxt[clr_idx] = 1'b0;
        end
        if (set_en) begin
            pend_nxt[iss_rd] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            pend <= pend_nxt;
        end
    end

endmodule

// File: rtl/br_wb_ctrl.sv
// Write-back controller: round-robin arbitration of ALU and load results onto
// the single BR write port, plus the pending scoreboard driving decode stalls.
module br_wb_ctrl
    import br_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned NREGS = NREGS_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     a_valid,
    input  logic [$clog2(NREGS)-1:0] a_rd,
    input  logic [XLEN-1:0]          a_data,
    output logic                     a_ready,
    input  logic                     b_valid,
    input  logic [$clog2(NREGS)-1:0] b_rd,
    input  logic [XLEN-1:0]          b_data,
    output logic                     b_ready,
    input  logic                     iss_valid,
    input  logic                     iss_wr,
    input  logic [$clog2(NREGS)-1:0] iss_rs1,
    input  logic [$clog2(NREGS)-1:0] iss_rs2,
    input  logic [$clog2(NREGS)-1:0] iss_rd,
    output logic                     stall,
    output logic [$clog2(NREGS)-1:0] a3,
    output logic [XLEN-1:0]          wd3,
    output logic                     we
);

    src_t                     last;
    src_t                     last_nxt;
    logic                     a_acc;
    logic                     b_acc;
    logic [$clog2(NREGS)-1:0] g_rd;
    logic [XLEN-1:0]          g_data;

    assign a_ready = ~b_valid | (last == SRC_B);
    assign b_ready = ~a_valid | (last == SRC_A);
    assign a_acc   = a_valid & a_ready;
    assign b_acc   = b_valid & b_ready;

    // At most one of a_acc/b_acc can be high, so B only needs to override A.
    always_comb begin
        last_nxt = last;
        g_rd     = a_rd;
        g_data   = a_data;
        if (b_acc) begin
            last_nxt = SRC_B;
            g_rd     = b_rd;
            g_data   = b_data;
        end else if (a_acc) begin
            last_nxt = SRC_A;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= SRC_B;
        end else begin
            last <= last_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a3  <= '0;
            wd3 <= '0;
            we  <= 1'b0;
        end else if (a_acc | b_acc) begin
            a3  <= g_rd;
            wd3 <= g_data;
            we  <= (g_rd != '0);
        end else begin
            we  <= 1'b0;
        end
    end

    br_scoreboard #(
        .NREGS (NREGS)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .iss_valid (iss_valid),
        .iss_wr    (iss_wr),
        .iss_rs1   (iss_rs1),
        .iss_rs2   (iss_rs2),
        .iss_rd    (iss_rd),
        .clr_en    (we),
        .clr_idx   (a3),
        .stall     (stall)
    );

endmodule
